// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: state encoding,
// PC constants and the PC increment helper.
package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_REQ     = 2'd0;
  localparam fetch_state_t ST_WAIT    = 2'd1;
  localparam fetch_state_t ST_HOLD    = 2'd2;
  localparam fetch_state_t ST_DISCARD = 2'd3;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  // Wraps modulo 2^32 by construction of the 32-bit result.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {valid, addr, instr} holding register. Catches a response that
// arrives while the output register is stalled. Clear beats load beats pop.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        pop_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] addr_o,
  output logic [31:0] instr_o
);

  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    if (clear_i) begin
      valid_d = 1'b0;
      addr_d  = '0;
      instr_d = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      instr_d = instr_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
      addr_d  = '0;
      instr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one outstanding imem
// request at a time, and delivers (addr, instr) into the IF/ID register.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] addr_o,
  output logic [31:0] instr_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         started_q;
  logic         out_v_q, out_v_d;
  logic [31:0]  out_addr_q, out_addr_d;
  logic [31:0]  out_instr_q, out_instr_d;

  logic         skid_v;
  logic [31:0]  skid_addr, skid_instr;
  logic         skid_load, skid_pop, skid_clear;

  logic         accept, consume, redir_to_discard;

  // started_q keeps the request low for the first cycle out of reset.
  assign imem_req_o  = started_q && (state_q == ST_REQ);
  assign imem_addr_o = pc_q;

  assign accept  = imem_req_o && imem_ready_i;
  assign consume = out_v_q && !stall_i;

  // A redirect only has to swallow a response that is still on its way.
  assign redir_to_discard = ((state_q == ST_WAIT)    && !imem_rvalid_i) ||
                            ((state_q == ST_REQ)     && accept)         ||
                            ((state_q == ST_DISCARD) && !imem_rvalid_i);

  fetch_skid_buf u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (skid_clear),
    .load_i  (skid_load),
    .pop_i   (skid_pop),
    .addr_i  (pc_q),
    .instr_i (imem_rdata_i),
    .valid_o (skid_v),
    .addr_o  (skid_addr),
    .instr_o (skid_instr)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_v_d     = out_v_q;
    out_addr_d  = out_addr_q;
    out_instr_d = out_instr_q;
    skid_load   = 1'b0;
    skid_pop    = 1'b0;
    skid_clear  = 1'b0;

    if (consume) begin
      out_v_d     = 1'b0;
      out_addr_d  = '0;
      out_instr_d = '0;
    end

    case (state_q)
      ST_REQ: begin
        if (accept) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          pc_d = pc_inc(pc_q);
          if (!out_v_q || consume) begin
            out_v_d     = 1'b1;
            out_addr_d  = pc_q;
            out_instr_d = imem_rdata_i;
            state_d     = ST_REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (consume && skid_v) begin
          out_v_d     = 1'b1;
          out_addr_d  = skid_addr;
          out_instr_d = skid_instr;
          skid_pop    = 1'b1;
          state_d     = ST_REQ;
        end
      end
      default: begin
        if (imem_rvalid_i) state_d = ST_REQ;
      end
    endcase

    if (redirect_i) begin
      pc_d        = redirect_pc_i & PC_ALIGN_MASK;
      out_v_d     = 1'b0;
      out_addr_d  = '0;
      out_instr_d = '0;
      skid_load   = 1'b0;
      skid_pop    = 1'b0;
      skid_clear  = 1'b1;
      state_d     = redir_to_discard ? ST_DISCARD : ST_REQ;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      started_q   <= 1'b0;
      out_v_q     <= 1'b0;
      out_addr_q  <= '0;
      out_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      started_q   <= 1'b1;
      out_v_q     <= out_v_d;
      out_addr_q  <= out_addr_d;
      out_instr_q <= out_instr_d;
    end
  end

  assign valid_o = out_v_q;
  assign addr_o  = out_addr_q;
  assign instr_o = out_instr_q;

endmodule
